// File: rtl/arb_pkg.sv
// Shared types and constants for the two-CPU RAM bus arbiter.
// Pure declarations, so there is no latency.
// No flow control of its own; it only describes the request classes and RAM status codes.
package arb_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // RAM status as reported by the memory controller
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } arb_state_t;

    // Request class, ordered so that a larger value means higher priority
    typedef enum logic [1:0] {
        NONE   = 2'd0,
        IREAD  = 2'd1,
        DREAD  = 2'd2,
        DWRITE = 2'd3
    } req_t;

    // Highest-priority class for one CPU; a write wins over a simultaneous data read
    function automatic req_t classify(input logic iren, input logic dren, input logic dwen);
        if (dwen)      return DWRITE;
        else if (dren) return DREAD;
        else if (iren) return IREAD;
        else           return NONE;
    endfunction

endpackage

// File: rtl/arb_prio_sel.sv
// Picks the next RAM owner: round-robin between the two CPUs, fixed class priority inside a CPU.
// Purely combinational, zero latency.
// No backpressure; the caller samples the pick only when it is ready to grant.
module arb_prio_sel
    import arb_pkg::*;
(
    input  logic [1:0] iren,
    input  logic [1:0] dren,
    input  logic [1:0] dwen,
    input  logic       rr_ptr,
    output logic       valid,
    output logic       cpu,
    output req_t       cls
);

    req_t c0;
    req_t c1;
    req_t c_pref;
    req_t c_other;

    // Favour the CPU named by rr_ptr; fall back to the other one only if it is silent
    always_comb begin
        c0      = classify(iren[0], dren[0], dwen[0]);
        c1      = classify(iren[1], dren[1], dwen[1]);
        c_pref  = rr_ptr ? c1 : c0;
        c_other = rr_ptr ? c0 : c1;
        valid   = 1'b1;
        cpu     = rr_ptr;
        cls     = c_pref;
        if (c_pref == NONE) begin
            cpu   = ~rr_ptr;
            cls   = c_other;
            valid = (c_other != NONE);
        end
    end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Shares one RAM port between the instruction and data sides of two CPUs; optional counters under ARB_STATS_EN.
// Latency: one IDLE arbitration cycle, then SERVE until RAM reports ACCESS (minimum 2 cycles to wait low).
// Backpressure: requesters stall on iwait/dwait until their single-cycle completion pulse; RAM stalls via ramstate.
module ram_bus_arbiter
    import arb_pkg::*;
#(
    parameter int CPUS    = 2,
    parameter int WORD_W  = arb_pkg::WORD_W,
    parameter int RR_INIT = 0
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [CPUS-1:0]               iREN,
    input  logic [CPUS-1:0]               dREN,
    input  logic [CPUS-1:0]               dWEN,
    input  logic [CPUS-1:0][WORD_W-1:0]   iaddr,
    input  logic [CPUS-1:0][WORD_W-1:0]   daddr,
    input  logic [CPUS-1:0][WORD_W-1:0]   dstore,
    output logic [CPUS-1:0]               iwait,
    output logic [CPUS-1:0]               dwait,
    output logic [CPUS-1:0][WORD_W-1:0]   iload,
    output logic [CPUS-1:0][WORD_W-1:0]   dload,
    output logic [WORD_W-1:0]             ramaddr,
    output logic [WORD_W-1:0]             ramstore,
    output logic                          ramREN,
    output logic                          ramWEN,
    input  logic [WORD_W-1:0]             ramload,
    input  logic [1:0]                    ramstate
`ifdef ARB_STATS_EN
    ,
    output logic [CPUS-1:0][WORD_W-1:0]   grant_cnt,
    output logic [WORD_W-1:0]             conflict_cnt
`endif
);

    arb_state_t state;
    logic       rr_ptr;
    logic       own_cpu;
    req_t       own_cls;

    logic       sel_vld;
    logic       sel_cpu;
    req_t       sel_cls;

    logic       own_live;
    logic       serving;
    logic       done;

    arb_prio_sel u_sel (
        .iren   (iREN),
        .dren   (dREN),
        .dwen   (dWEN),
        .rr_ptr (rr_ptr),
        .valid  (sel_vld),
        .cpu    (sel_cpu),
        .cls    (sel_cls)
    );

    // The owner keeps its grant only while the request it was granted for is still raised
    always_comb begin
        case (own_cls)
            IREAD:   own_live = iREN[own_cpu];
            DREAD:   own_live = dREN[own_cpu];
            DWRITE:  own_live = dWEN[own_cpu];
            default: own_live = 1'b0;
        endcase
    end

    assign serving = (state == SERVE) && own_live;
    assign done    = serving && (ramstate_t'(ramstate) == ACCESS);

    // RAM port muxing and wait generation; an ERROR status simply keeps the access pending
    always_comb begin
        ramREN   = serving && (own_cls != DWRITE);
        ramWEN   = serving && (own_cls == DWRITE);
        ramaddr  = '0;
        ramstore = '0;
        if (state == SERVE) begin
            ramaddr  = (own_cls == IREAD) ? iaddr[own_cpu] : daddr[own_cpu];
            ramstore = dstore[own_cpu];
        end
        iwait = '1;
        dwait = '1;
        if (done) begin
            if (own_cls == IREAD) iwait[own_cpu] = 1'b0;
            else                  dwait[own_cpu] = 1'b0;
        end
    end

    // Read data is broadcast; only the owner's wait pulse tells it the data is valid
    assign iload = {CPUS{ramload}};
    assign dload = {CPUS{ramload}};

    // Grant FSM: latch one owner in IDLE, hold it until completion or abort
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            rr_ptr  <= RR_INIT[0];
            own_cpu <= 1'b0;
            own_cls <= NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        own_cpu <= sel_cpu;
                        own_cls <= sel_cls;
                        state   <= SERVE;
                    end
                end
                SERVE: begin
                    if (!own_live) begin
                        // abort: priority stays where it was
                        state   <= IDLE;
                        own_cls <= NONE;
                    end else if (done) begin
                        state   <= IDLE;
                        own_cls <= NONE;
                        rr_ptr  <= ~own_cpu;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    logic [CPUS-1:0] any_req;
    assign any_req = iREN | dREN | dWEN;

    // Completed-grant and contention counters, free-running with natural wrap
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            grant_cnt    <= '0;
            conflict_cnt <= '0;
        end else begin
            if (done)
                grant_cnt[own_cpu] <= grant_cnt[own_cpu] + 1'b1;
            if ((state == IDLE) && (&any_req))
                conflict_cnt <= conflict_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Scoreboard bench for ram_bus_arbiter: directed requests, expected completions queued in grant order.
// Latency is checked implicitly through ordering and the RAM status at each completion pulse.
// The RAM model inserts programmable BUSY/ERROR stalls ahead of ACCESS.
module tb_ram_bus_arbiter;

    localparam logic [1:0] K_I  = 2'd0;
    localparam logic [1:0] K_DR = 2'd1;
    localparam logic [1:0] K_DW = 2'd2;

    logic              CLK;
    logic              RST;
    logic [1:0]        iREN, dREN, dWEN;
    logic [1:0][31:0]  iaddr, daddr, dstore;
    logic [1:0]        iwait, dwait;
    logic [1:0][31:0]  iload, dload;
    logic [31:0]       ramaddr, ramstore, ramload;
    logic              ramREN, ramWEN;
    logic [1:0]        ramstate;
`ifdef ARB_STATS_EN
    logic [1:0][31:0]  grant_cnt;
    logic [31:0]       conflict_cnt;
`endif

    ram_bus_arbiter #(.CPUS(2), .WORD_W(32), .RR_INIT(0)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramload(ramload), .ramstate(ramstate)
`ifdef ARB_STATS_EN
        , .grant_cnt(grant_cnt), .conflict_cnt(conflict_cnt)
`endif
    );

    typedef struct {
        int          ch;
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] data;
    } item_t;

    typedef struct {
        int          cpu;
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] load;
    } exp_t;

    item_t       pend[$];
    exp_t        sbq[$];
    item_t       cur[4];
    logic [3:0]  ch_act;
    logic [3:0]  abort_ch;
    logic [3:0]  wlow;
    int          total;
    int          bad;
    int          ram_lat;
    int          ram_cnt;
    logic [1:0]  ram_stall;

    function automatic logic [31:0] ram_fn(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : ~a;
    endfunction

    assign ramload = ram_fn(ramaddr);

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required finish");
        $fatal(1, "watchdog");
    end

    // RAM model: stall for ram_lat enabled cycles, then ACCESS
    initial begin
        ramstate = 2'd0;
        ram_cnt  = 0;
        forever begin
            @(posedge CLK); #2;
            if (ramREN || ramWEN) begin
                ramstate = (ram_cnt >= ram_lat) ? 2'd2 : ram_stall;
                ram_cnt++;
            end else begin
                ram_cnt  = 0;
                ramstate = 2'd0;
            end
        end
    end

    // CPU-side driver: one outstanding request per channel, held until its wait pulse
    initial begin
        iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        ch_act = '0;
        abort_ch = '0;
        forever begin
            @(posedge CLK); #1;
            for (int ch = 0; ch < 4; ch++) begin
                if (ch_act[ch] && (wlow[ch] || abort_ch[ch])) ch_act[ch] = 1'b0;
                abort_ch[ch] = 1'b0;
                for (int k = 0; k < pend.size(); k++) begin
                    if (!ch_act[ch] && pend[k].ch == ch) begin
                        cur[ch] = pend[k];
                        pend.delete(k);
                        ch_act[ch] = 1'b1;
                    end
                end
            end
            for (int c = 0; c < 2; c++) begin
                iREN[c]   = ch_act[2*c];
                iaddr[c]  = ch_act[2*c] ? cur[2*c].addr : 32'h0;
                dREN[c]   = ch_act[2*c+1] && (cur[2*c+1].kind == K_DR);
                dWEN[c]   = ch_act[2*c+1] && (cur[2*c+1].kind == K_DW);
                daddr[c]  = ch_act[2*c+1] ? cur[2*c+1].addr : 32'h0;
                dstore[c] = ch_act[2*c+1] ? cur[2*c+1].data : 32'h0;
            end
        end
    end

    task automatic check_evt(input int c, input int s);
        exp_t        e;
        logic        ok;
        logic [31:0] ld;
        total++;
        ld = (s != 0) ? dload[c] : iload[c];
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_wait: cpu%0d side%0d addr=%0h state=%0d, required no completion", c, s, ramaddr, ramstate);
            return;
        end
        e  = sbq.pop_front();
        ok = (e.cpu == c) && ((e.kind == K_I) == (s == 0)) && (ramaddr == e.addr) && (ramstate == 2'd2);
        if (e.kind == K_DW) ok = ok && ramWEN && !ramREN && (ramstore == e.data);
        else                ok = ok && ramREN && !ramWEN && (ld == e.load);
        if (!ok)
            $display("FAIL completion: got cpu%0d side%0d addr=%0h ren=%0b wen=%0b store=%0h load=%0h rs=%0d, required cpu%0d kind%0d addr=%0h store=%0h load=%0h rs=2",
                     c, s, ramaddr, ramREN, ramWEN, ramstore, ld, ramstate, e.cpu, e.kind, e.addr, e.data, e.load);
        if (!ok) bad++;
    endtask

    // Monitor: every wait-low pulse is a completion and is matched against the scoreboard
    initial begin
        wlow = '0;
        forever begin
            @(negedge CLK);
            for (int c = 0; c < 2; c++) begin
                wlow[2*c]   = !iwait[c];
                wlow[2*c+1] = !dwait[c];
                if (!iwait[c]) check_evt(c, 0);
                if (!dwait[c]) check_evt(c, 1);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h required=%0h", nm, got, exp);
        end
    endtask

    task automatic req(input int cpu, input logic [1:0] kind, input logic [31:0] addr,
                       input logic [31:0] data, input bit push);
        item_t it;
        exp_t  e;
        it.ch   = cpu*2 + ((kind == K_I) ? 0 : 1);
        it.kind = kind;
        it.addr = addr;
        it.data = data;
        pend.push_back(it);
        if (push) begin
            e.cpu  = cpu;
            e.kind = kind;
            e.addr = addr;
            e.data = data;
            e.load = ram_fn(addr);
            sbq.push_back(e);
        end
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((pend.size() != 0 || ch_act != 4'b0 || sbq.size() != 0) && n < 300) begin
            @(posedge CLK); #3;
            n++;
        end
        total++;
        if (n >= 300) begin
            bad++;
            $display("FAIL %s timeout: pending=%0d outstanding=%0d, required 0", nm, pend.size(), sbq.size());
            sbq.delete();
            pend.delete();
        end
        repeat (2) @(posedge CLK);
        #3;
    endtask

    task automatic wait_en(input string nm);
        int n;
        n = 0;
        while (!(ramREN || ramWEN) && n < 50) begin
            @(posedge CLK); #3;
            n++;
        end
        chk(nm, {31'b0, ramREN | ramWEN}, 32'h1);
    endtask

`ifdef ARB_STATS_EN
    logic [31:0] g_before;
`endif

    initial begin
        total     = 0;
        bad       = 0;
        ram_lat   = 0;
        ram_stall = 2'd1;
        RST       = 1'b0;
        #1 RST    = 1'b1;
        repeat (2) @(posedge CLK);
        #3;
        chk("rst_iwait", {30'b0, iwait}, 32'h3);
        chk("rst_dwait", {30'b0, dwait}, 32'h3);
        chk("rst_ramREN", {31'b0, ramREN}, 32'h0);
        chk("rst_ramWEN", {31'b0, ramWEN}, 32'h0);
        chk("rst_ramaddr", ramaddr, 32'h0);
        chk("rst_ramstore", ramstore, 32'h0);
        RST = 1'b0;

        // reset arriving mid-SERVE
        ram_lat = 20;
        req(1, K_I, 32'h200, 32'h0, 1'b0);
        wait_en("mid_serve_en");
        RST = 1'b1;
        #1;
        chk("mid_rst_ramREN", {31'b0, ramREN}, 32'h0);
        chk("mid_rst_iwait", {30'b0, iwait}, 32'h3);
        chk("mid_rst_dwait", {30'b0, dwait}, 32'h3);
        pend.delete();
        ch_act = '0;
        repeat (2) @(posedge CLK);
        #3;
        RST     = 1'b0;
        ram_lat = 0;
        req(0, K_DR, 32'h310, 32'h0, 1'b1);
        req(1, K_DR, 32'h300, 32'h0, 1'b1);
        drain("after_reset");

        // single instruction read, ACCESS on second SERVE cycle
        ram_lat = 1;
        req(0, K_I, 32'h100, 32'h0, 1'b1);
        wait_en("iread_en");
        chk("iread_addr_busy", ramaddr, 32'h100);
        drain("iread");

        // both CPUs streaming data reads from rr_ptr=0: strict alternation
        ram_lat = 0;
        req(1, K_DR, 32'h500, 32'h0, 1'b1);
        drain("rr_setup");
        for (int i = 0; i < 4; i++) begin
            req(0, K_DR, 32'h600 + 32'(i*4), 32'h0, 1'b1);
            req(1, K_DR, 32'h700 + 32'(i*4), 32'h0, 1'b1);
        end
        drain("alternate");

        // write beats instruction read within one CPU
        req(1, K_DW, 32'h40, 32'h5, 1'b1);
        req(1, K_I, 32'h80, 32'h0, 1'b1);
        drain("class_prio");

        // abort during BUSY
        ram_lat = 50;
        req(0, K_DR, 32'h900, 32'h0, 1'b0);
        wait_en("abort_en");
        abort_ch[1] = 1'b1;
        @(posedge CLK); #3;
        chk("abort_ramREN", {31'b0, ramREN}, 32'h0);
        chk("abort_dwait", {30'b0, dwait}, 32'h3);
        @(posedge CLK); #3;
        chk("abort_idle_ramREN", {31'b0, ramREN}, 32'h0);
        ram_lat = 0;
        req(1, K_DR, 32'hA00, 32'h0, 1'b1);
        req(0, K_DR, 32'hA10, 32'h0, 1'b0);
        sbq.push_front('{cpu: 0, kind: K_DR, addr: 32'hA10, data: 32'h0, load: ram_fn(32'hA10)});
        drain("abort_rr");

        // ERROR retries then ACCESS
`ifdef ARB_STATS_EN
        g_before = grant_cnt[1];
`endif
        ram_lat   = 3;
        ram_stall = 2'd3;
        req(1, K_DR, 32'hB00, 32'h0, 1'b1);
        drain("error_retry");
`ifdef ARB_STATS_EN
        chk("grant_cnt_inc", grant_cnt[1], g_before + 32'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
